// File: rtl/alu_arbiter_2.sv
// -----------------------------------------------------------------------------
// alu_arbiter_2
//   Shares a single ALU between two requesters (e.g. execute stage on r0 and
//   branch-compare on r1). Requests arrive on valid/ready channels and are
//   granted round-robin. The granted operation is latched, launched with a
//   one-cycle alu_start pulse, and its result/status is returned on the
//   granted requester's valid/ready response channel. A watchdog forces a
//   timeout response if the ALU never reports finished.
//
//   Only one operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESPOND.
//
// Parameters
//   WORD_SIZE       operand/result width
//   TIMEOUT_CYCLES  WAIT cycles before a forced timeout response (>= 2)
//   CNT_W           watchdog counter width, must hold TIMEOUT_CYCLES
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   rN_req_valid/ready           request handshake for requester N (N = 0, 1)
//   rN_a, rN_b, rN_control       operands and ALU control code (forwarded as-is)
//   rN_rsp_valid/ready           response handshake for requester N
//   rN_result, rN_flags          captured result and
//                                {timeout, invalid_control, overflow, cout, zero}
//   alu_start                    one-cycle launch pulse to the ALU
//   alu_input_a/b, alu_control   latched operation driven to the ALU
//   alu_finished, alu_result     ALU completion and result
//   alu_zero/cout/overflow/invalid_control  ALU status bits
//
// Optional build macro ALU_ARB_STATS_EN
//   Adds saturating statistics outputs stat_ops0, stat_ops1 (accepted requests
//   per requester, 16 bit) and stat_timeouts (watchdog expiries, 8 bit).
// -----------------------------------------------------------------------------
module alu_arbiter_2 #(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 r0_req_valid,
  output logic                 r0_req_ready,
  input  logic [WORD_SIZE-1:0] r0_a,
  input  logic [WORD_SIZE-1:0] r0_b,
  input  logic [3:0]           r0_control,
  output logic                 r0_rsp_valid,
  input  logic                 r0_rsp_ready,
  output logic [WORD_SIZE-1:0] r0_result,
  output logic [4:0]           r0_flags,

  input  logic                 r1_req_valid,
  output logic                 r1_req_ready,
  input  logic [WORD_SIZE-1:0] r1_a,
  input  logic [WORD_SIZE-1:0] r1_b,
  input  logic [3:0]           r1_control,
  output logic                 r1_rsp_valid,
  input  logic                 r1_rsp_ready,
  output logic [WORD_SIZE-1:0] r1_result,
  output logic [4:0]           r1_flags,

  output logic                 alu_start,
  output logic [WORD_SIZE-1:0] alu_input_a,
  output logic [WORD_SIZE-1:0] alu_input_b,
  output logic [3:0]           alu_control,
  input  logic                 alu_finished,
  input  logic [WORD_SIZE-1:0] alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_cout,
  input  logic                 alu_overflow,
  input  logic                 alu_invalid_control
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]          stat_ops0,
  output logic [15:0]          stat_ops1,
  output logic [7:0]           stat_timeouts
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic                 last_grant;   // id of the most recently granted requester
  logic                 grant_id;     // id owning the operation in flight
  logic [CNT_W-1:0]     watchdog;

  logic                 grant1;
  logic                 accept0;
  logic                 accept1;
  logic                 rsp_ready_g;
  logic                 wd_expired;
  logic                 timeout_evt;

  // Operation latched at acceptance (feeds the ALU from ISSUE onward)
  logic [WORD_SIZE-1:0] op_a_p0;
  logic [WORD_SIZE-1:0] op_b_p0;
  logic [3:0]           op_ctrl_p0;

  // Response captured at the end of WAIT
  logic [WORD_SIZE-1:0] rsp_result_p1;
  logic [4:0]           rsp_flags_p1;

  // Round-robin: on a tie the requester that did not win last time is granted.
  assign grant1      = r1_req_valid && (!r0_req_valid || !last_grant);
  assign accept0     = (state == IDLE) && r0_req_valid && !grant1;
  assign accept1     = (state == IDLE) && grant1;
  assign rsp_ready_g = grant_id ? r1_rsp_ready : r0_rsp_ready;
  assign wd_expired  = (watchdog == CNT_W'(TIMEOUT_CYCLES - 1));
  // A finished in the same cycle as expiry takes priority over the timeout.
  assign timeout_evt = (state == WAIT) && !alu_finished && wd_expired;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept0 || accept1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_finished || wd_expired) state_nxt = RESPOND;
      RESPOND: if (rsp_ready_g) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      grant_id      <= 1'b0;
      watchdog      <= '0;
      op_a_p0       <= '0;
      op_b_p0       <= '0;
      op_ctrl_p0    <= '0;
      rsp_result_p1 <= '0;
      rsp_flags_p1  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        // p0: capture the granted request
        IDLE: begin
          if (accept0 || accept1) begin
            op_a_p0    <= accept1 ? r1_a : r0_a;
            op_b_p0    <= accept1 ? r1_b : r0_b;
            op_ctrl_p0 <= accept1 ? r1_control : r0_control;
            grant_id   <= accept1;
            last_grant <= accept1;
          end
        end
        ISSUE: watchdog <= '0;
        // p1: capture the ALU outcome or the forced timeout
        WAIT: begin
          if (alu_finished) begin
            rsp_result_p1 <= alu_result;
            rsp_flags_p1  <= {1'b0, alu_invalid_control, alu_overflow,
                              alu_cout, alu_zero};
          end else if (wd_expired) begin
            rsp_result_p1 <= '0;
            rsp_flags_p1  <= 5'b10000;
          end else begin
            watchdog <= watchdog + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign r0_req_ready = accept0;
  assign r1_req_ready = accept1;
  assign r0_rsp_valid = (state == RESPOND) && !grant_id;
  assign r1_rsp_valid = (state == RESPOND) && grant_id;
  assign r0_result    = rsp_result_p1;
  assign r1_result    = rsp_result_p1;
  assign r0_flags     = rsp_flags_p1;
  assign r1_flags     = rsp_flags_p1;

  assign alu_start    = (state == ISSUE);
  assign alu_input_a  = op_a_p0;
  assign alu_input_b  = op_b_p0;
  assign alu_control  = op_ctrl_p0;

`ifdef ALU_ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_ops0     <= '0;
      stat_ops1     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (accept0)     stat_ops0     <= sat_inc16(stat_ops0);
      if (accept1)     stat_ops1     <= sat_inc16(stat_ops1);
      if (timeout_evt) stat_timeouts <= sat_inc8(stat_timeouts);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter_2.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter_2
//   Directed bench for alu_arbiter_2. A small behavioural ALU answers
//   alu_start after a programmable delay (or never, or with a stale early
//   finished). Each scenario task drives requests and compares the DUT
//   outputs against hand-computed values.
//   ALU codes used by the model: 0 AND, 1 OR, 2 ADD, 6 SUB, others invalid.
// -----------------------------------------------------------------------------
module tb_alu_arbiter_2;

  localparam int WS = 32;
  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_SUB = 4'h6;

  logic          clock = 1'b0;
  logic          reset;
  logic          r0_req_valid, r0_req_ready, r0_rsp_valid, r0_rsp_ready;
  logic [WS-1:0] r0_a, r0_b, r0_result;
  logic [3:0]    r0_control;
  logic [4:0]    r0_flags;
  logic          r1_req_valid, r1_req_ready, r1_rsp_valid, r1_rsp_ready;
  logic [WS-1:0] r1_a, r1_b, r1_result;
  logic [3:0]    r1_control;
  logic [4:0]    r1_flags;
  logic          alu_start, alu_finished;
  logic [WS-1:0] alu_input_a, alu_input_b, alu_result;
  logic [3:0]    alu_control;
  logic          alu_zero, alu_cout, alu_overflow, alu_invalid_control;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   stat_ops0, stat_ops1;
  logic [7:0]    stat_timeouts;
`endif

  int checks = 0;
  int errors = 0;

  // ALU model controls
  bit  alu_hang  = 1'b0;
  bit  alu_stale = 1'b0;
  int  alu_delay = 1;
  bit  alu_busy  = 1'b0;
  int  alu_remain = 0;
  logic [WS:0] alu_sum;

  alu_arbiter_2 #(.WORD_SIZE(32), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r0_control(r0_control),
    .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_result(r0_result), .r0_flags(r0_flags),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_a(r1_a), .r1_b(r1_b), .r1_control(r1_control),
    .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_result(r1_result), .r1_flags(r1_flags),
    .alu_start(alu_start), .alu_input_a(alu_input_a),
    .alu_input_b(alu_input_b), .alu_control(alu_control),
    .alu_finished(alu_finished), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .alu_invalid_control(alu_invalid_control)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_ops0(stat_ops0), .stat_ops1(stat_ops1), .stat_timeouts(stat_timeouts)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural ALU: latches the launched operation, answers after alu_delay
  // cycles with a one-cycle finished pulse. Drives on the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      alu_busy     = 1'b0;
      alu_finished = 1'b0;
    end else begin
      alu_finished = 1'b0;
      if (alu_busy) begin
        alu_remain = alu_remain - 1;
        if (alu_remain == 0) begin
          alu_busy            = 1'b0;
          alu_finished        = 1'b1;
          alu_cout            = 1'b0;
          alu_overflow        = 1'b0;
          alu_invalid_control = 1'b0;
          case (alu_control)
            C_AND: alu_result = alu_input_a & alu_input_b;
            C_OR:  alu_result = alu_input_a | alu_input_b;
            C_ADD: begin
              alu_sum      = {1'b0, alu_input_a} + {1'b0, alu_input_b};
              alu_result   = alu_sum[WS-1:0];
              alu_cout     = alu_sum[WS];
              alu_overflow = (alu_input_a[WS-1] == alu_input_b[WS-1]) &&
                             (alu_result[WS-1] != alu_input_a[WS-1]);
            end
            C_SUB: begin
              alu_result   = alu_input_a - alu_input_b;
              alu_overflow = (alu_input_a[WS-1] != alu_input_b[WS-1]) &&
                             (alu_result[WS-1] != alu_input_a[WS-1]);
            end
            default: begin
              alu_result          = '0;
              alu_invalid_control = 1'b1;
            end
          endcase
          alu_zero = (alu_result == '0);
        end
      end
      if (alu_start) begin
        alu_busy   = !alu_hang;
        alu_remain = alu_delay;
        if (alu_stale) begin
          // Premature finished during the launch cycle with a junk result
          alu_finished        = 1'b1;
          alu_result          = 32'hDEADBEEF;
          alu_zero            = 1'b0;
          alu_cout            = 1'b1;
          alu_overflow        = 1'b1;
          alu_invalid_control = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic idle_inputs();
    r0_req_valid = 0; r0_rsp_ready = 0; r0_a = '0; r0_b = '0; r0_control = '0;
    r1_req_valid = 0; r1_rsp_ready = 0; r1_a = '0; r1_b = '0; r1_control = '0;
    alu_finished = 0; alu_result = '0; alu_zero = 0; alu_cout = 0;
    alu_overflow = 0; alu_invalid_control = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_req0(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic [3:0] c);
    r0_a = a; r0_b = b; r0_control = c; r0_req_valid = 1'b1;
  endtask

  task automatic set_req1(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic [3:0] c);
    r1_a = a; r1_b = b; r1_control = c; r1_req_valid = 1'b1;
  endtask

  // Steps falling edges until any response is valid; waited = -1 on expiry.
  task automatic wait_rsp(input int max, output int waited);
    waited = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (r0_rsp_valid || r1_rsp_valid) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic handshake(input bit which);
    if (which) r1_rsp_ready = 1'b1; else r0_rsp_ready = 1'b1;
    @(negedge clock);
    r0_rsp_ready = 1'b0;
    r1_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (alu_start !== 1'b0) begin errors++; $display("FAIL reset_alu_start: got %b want 0", alu_start); end
    checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", {r0_rsp_valid, r1_rsp_valid}); end
    checks++; if ({alu_input_a, alu_input_b, alu_control} !== '0) begin errors++; $display("FAIL reset_alu_operands: got %h %h %h want 0", alu_input_a, alu_input_b, alu_control); end
    checks++; if ({r0_result, r0_flags, r1_result, r1_flags} !== '0) begin errors++; $display("FAIL reset_results: got %h/%b want 0", r0_result, r0_flags); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if ({r0_req_ready, r1_req_ready} !== 2'b00) begin errors++; $display("FAIL idle_no_req_ready: got %b want 00", {r0_req_ready, r1_req_ready}); end
  endtask

  task automatic test_single();
    int w;
    alu_delay = 1;
    set_req0(32'd3, 32'd1, C_ADD);
    #1;
    checks++; if ({r0_req_ready, r1_req_ready} !== 2'b10) begin errors++; $display("FAIL single_req_ready: got %b want 10", {r0_req_ready, r1_req_ready}); end
    @(negedge clock);  // T+1
    r0_req_valid = 1'b0;
    checks++; if (alu_start !== 1'b1) begin errors++; $display("FAIL single_start_T1: got %b want 1", alu_start); end
    checks++; if ({alu_input_a, alu_input_b, alu_control} !== {32'd3, 32'd1, C_ADD}) begin errors++; $display("FAIL single_alu_inputs: got %h %h %h want 3 1 2", alu_input_a, alu_input_b, alu_control); end
    @(negedge clock);  // T+2
    checks++; if ({alu_start, r0_rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_T2: start/rsp got %b want 00", {alu_start, r0_rsp_valid}); end
    wait_rsp(10, w);   // expect T+3
    checks++; if (w !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", w); end
    checks++; if ({r0_rsp_valid, r1_rsp_valid} !== 2'b10) begin errors++; $display("FAIL single_rsp_valid: got %b want 10", {r0_rsp_valid, r1_rsp_valid}); end
    checks++; if ({r0_result, r0_flags} !== {32'd4, 5'b00000}) begin errors++; $display("FAIL single_result: got %h/%b want 4/00000", r0_result, r0_flags); end
    handshake(0);
    checks++; if (r0_rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b want 0", r0_rsp_valid); end
  endtask

  task automatic test_tie();
    int w;
    do_reset();
    alu_delay = 1;
    set_req0(32'd1, 32'd1, C_SUB);
    set_req1(32'd2, 32'd1, C_OR);
    #1;
    checks++; if ({r0_req_ready, r1_req_ready} !== 2'b10) begin errors++; $display("FAIL tie1_grant: got %b want 10", {r0_req_ready, r1_req_ready}); end
    @(negedge clock);
    r0_req_valid = 1'b0;
    checks++; if (r1_req_ready !== 1'b0) begin errors++; $display("FAIL tie1_busy_ready: got %b want 0", r1_req_ready); end
    wait_rsp(10, w);
    checks++; if (w !== 2) begin errors++; $display("FAIL tie1_r0_latency: got %0d want 2", w); end
    checks++; if ({r0_rsp_valid, r1_rsp_valid, r0_result, r0_flags} !== {2'b10, 32'd0, 5'b00001}) begin errors++; $display("FAIL tie1_r0_rsp: got %b%b %h/%b want 10 0/00001", r0_rsp_valid, r1_rsp_valid, r0_result, r0_flags); end
    handshake(0);
    checks++; if (r1_req_ready !== 1'b1) begin errors++; $display("FAIL tie1_r1_granted: got %b want 1", r1_req_ready); end
    @(negedge clock);
    r1_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r0_rsp_valid, r1_rsp_valid, r1_result, r1_flags} !== {2'b01, 32'd3, 5'b00000}) begin errors++; $display("FAIL tie1_r1_rsp: got %b%b %h/%b want 01 3/00000", r0_rsp_valid, r1_rsp_valid, r1_result, r1_flags); end
    handshake(1);
    // r0 alone, so the next tie belongs to r1
    set_req0(32'd10, 32'd20, C_ADD);
    @(negedge clock);
    r0_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r0_rsp_valid, r0_result} !== {1'b1, 32'd30}) begin errors++; $display("FAIL solo_r0_rsp: got %b %h want 1 1e", r0_rsp_valid, r0_result); end
    handshake(0);
    set_req0(32'hF0, 32'h3C, C_AND);
    set_req1(32'd100, 32'd1, C_ADD);
    #1;
    checks++; if ({r0_req_ready, r1_req_ready} !== 2'b01) begin errors++; $display("FAIL tie2_grant: got %b want 01", {r0_req_ready, r1_req_ready}); end
    @(negedge clock);
    r1_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r1_rsp_valid, r1_result} !== {1'b1, 32'd101}) begin errors++; $display("FAIL tie2_r1_rsp: got %b %h want 1 65", r1_rsp_valid, r1_result); end
    handshake(1);
    checks++; if (r0_req_ready !== 1'b1) begin errors++; $display("FAIL tie2_r0_granted: got %b want 1", r0_req_ready); end
    @(negedge clock);
    r0_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r0_rsp_valid, r0_result, r0_flags} !== {1'b1, 32'h30, 5'b00000}) begin errors++; $display("FAIL tie2_r0_rsp: got %b %h/%b want 1 30/00000", r0_rsp_valid, r0_result, r0_flags); end
    handshake(0);
  endtask

  task automatic test_timeout();
    int w;
    // ALU never finishes: 16 WAIT cycles then a timeout response at T+18
    alu_hang = 1'b1;
    set_req0(32'd1, 32'd1, C_ADD);
    @(negedge clock);
    r0_req_valid = 1'b0;
    wait_rsp(40, w);
    checks++; if (w !== 17) begin errors++; $display("FAIL timeout_latency: got %0d want 17", w); end
    checks++; if ({r0_rsp_valid, r0_result, r0_flags} !== {1'b1, 32'd0, 5'b10000}) begin errors++; $display("FAIL timeout_rsp: got %b %h/%b want 1 0/10000", r0_rsp_valid, r0_result, r0_flags); end
    handshake(0);
    alu_hang = 1'b0;
    // Finished lands on the last WAIT cycle: finished wins over timeout
    alu_delay = 16;
    set_req0(32'd5, 32'd6, C_ADD);
    @(negedge clock);
    r0_req_valid = 1'b0;
    wait_rsp(40, w);
    checks++; if (w !== 17) begin errors++; $display("FAIL finish_wins_latency: got %0d want 17", w); end
    checks++; if ({r0_result, r0_flags} !== {32'd11, 5'b00000}) begin errors++; $display("FAIL finish_wins_rsp: got %h/%b want b/00000", r0_result, r0_flags); end
    handshake(0);
    // Finished during ISSUE is stale and must be ignored
    alu_delay = 3;
    alu_stale = 1'b1;
    set_req0(32'd7, 32'd8, C_ADD);
    @(negedge clock);
    r0_req_valid = 1'b0;
    alu_stale = 1'b0;
    wait_rsp(20, w);
    checks++; if (w !== 4) begin errors++; $display("FAIL stale_latency: got %0d want 4", w); end
    checks++; if ({r0_result, r0_flags} !== {32'd15, 5'b00000}) begin errors++; $display("FAIL stale_rsp: got %h/%b want f/00000", r0_result, r0_flags); end
    handshake(0);
    alu_delay = 1;
  endtask

  task automatic test_backpressure();
    int w;
    set_req1(32'h7FFFFFFF, 32'd1, C_ADD);
    #1;
    checks++; if (r1_req_ready !== 1'b1) begin errors++; $display("FAIL bp_r1_ready: got %b want 1", r1_req_ready); end
    @(negedge clock);
    r1_req_valid = 1'b0;
    set_req0(32'd2, 32'd2, C_ADD);
    wait_rsp(10, w);
    checks++; if (w !== 2) begin errors++; $display("FAIL bp_latency: got %0d want 2", w); end
    for (int i = 0; i < 5; i++) begin
      checks++; if ({r1_rsp_valid, r0_rsp_valid, r0_req_ready} !== 3'b100) begin errors++; $display("FAIL bp_hold_ctl[%0d]: got %b want 100", i, {r1_rsp_valid, r0_rsp_valid, r0_req_ready}); end
      checks++; if ({r1_result, r1_flags} !== {32'h80000000, 5'b00100}) begin errors++; $display("FAIL bp_hold_rsp[%0d]: got %h/%b want 80000000/00100", i, r1_result, r1_flags); end
      @(negedge clock);
    end
    handshake(1);
    checks++; if ({r1_rsp_valid, r0_req_ready} !== 2'b01) begin errors++; $display("FAIL bp_release: got %b want 01", {r1_rsp_valid, r0_req_ready}); end
    @(negedge clock);
    r0_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r0_rsp_valid, r0_result} !== {1'b1, 32'd4}) begin errors++; $display("FAIL bp_r0_rsp: got %b %h want 1 4", r0_rsp_valid, r0_result); end
    handshake(0);
  endtask

  task automatic test_invalid();
    int w;
    set_req0(32'd5, 32'd6, 4'hF);
    @(negedge clock);
    r0_req_valid = 1'b0;
    checks++; if (alu_control !== 4'hF) begin errors++; $display("FAIL invalid_forward: got %h want f", alu_control); end
    wait_rsp(10, w);
    checks++; if ({r0_rsp_valid, r0_result, r0_flags} !== {1'b1, 32'd0, 5'b01001}) begin errors++; $display("FAIL invalid_rsp: got %b %h/%b want 1 0/01001", r0_rsp_valid, r0_result, r0_flags); end
    handshake(0);
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    checks++; if (stat_ops0 !== 16'd8) begin errors++; $display("FAIL stat_ops0: got %0d want 8", stat_ops0); end
    checks++; if (stat_ops1 !== 16'd3) begin errors++; $display("FAIL stat_ops1: got %0d want 3", stat_ops1); end
    checks++; if (stat_timeouts !== 8'd1) begin errors++; $display("FAIL stat_timeouts: got %0d want 1", stat_timeouts); end
  endtask
`endif

  task automatic test_reset_mid();
    int w;
    int seen;
    alu_hang = 1'b1;
    set_req0(32'd9, 32'd9, C_ADD);
    @(negedge clock);  // ISSUE
    r0_req_valid = 1'b0;
    @(negedge clock);  // WAIT
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({alu_start, r0_rsp_valid, r1_rsp_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_outputs: got %b want 000", {alu_start, r0_rsp_valid, r1_rsp_valid}); end
    checks++; if (alu_input_a !== 32'd0) begin errors++; $display("FAIL rstmid_operand_clear: got %h want 0", alu_input_a); end
    reset = 1'b0;
    alu_hang = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (r0_rsp_valid || r1_rsp_valid || alu_start) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_rsp: got %0d active cycles want 0", seen); end
    set_req0(32'd1, 32'd2, C_ADD);
    set_req1(32'd3, 32'd4, C_ADD);
    #1;
    checks++; if ({r0_req_ready, r1_req_ready} !== 2'b10) begin errors++; $display("FAIL rstmid_tie_grant: got %b want 10", {r0_req_ready, r1_req_ready}); end
    @(negedge clock);
    r0_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r0_rsp_valid, r0_result} !== {1'b1, 32'd3}) begin errors++; $display("FAIL rstmid_r0_rsp: got %b %h want 1 3", r0_rsp_valid, r0_result); end
    handshake(0);
    @(negedge clock);
    r1_req_valid = 1'b0;
    wait_rsp(10, w);
    checks++; if ({r1_rsp_valid, r1_result} !== {1'b1, 32'd7}) begin errors++; $display("FAIL rstmid_r1_rsp: got %b %h want 1 7", r1_rsp_valid, r1_result); end
    handshake(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_backpressure();
    test_invalid();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
